uart_transmitter: RTL

//   UART transmitter, 8N1, LSB-first, paced by the shared 16x-baud sample_tick.
//   A FIFO_DEPTH-entry write buffer decouples the producer from line timing.

---
 rtl/uart_transmitter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB-first, paced by a shared 16x-baud sample_tick.
// A small write FIFO decouples the producer from line timing.
`timescale 1ns/1ps
module uart_transmitter #(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_BIT_TICK = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned FIFO_AW       = 2
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned TICK_W  = 4;
  localparam int unsigned NBITS_W = $clog2(DATA_BITS);
  localparam int unsigned CNT_W   = FIFO_AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(STOP_BIT_TICK - 1);
  localparam logic [NBITS_W-1:0] NBITS_LAST = NBITS_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FIFO_DEPTH);

  logic [1:0]           state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [NBITS_W-1:0]   nbits_q, nbits_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 push;
  logic                 pop;

  // FIFO: full is registered, so a write in the same cycle as a pop from full is dropped
  always_comb begin
    push     = wr_en && !full_q;
    pop      = (state_q == ST_IDLE) && !empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Frame FSM; tx and status are registered from the next-state values
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    nbits_d = nbits_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          shift_d = mem_q[rd_ptr_q];
          tick_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            nbits_d = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (nbits_q == NBITS_LAST) begin
              state_d = ST_STOP;
            end else begin
              nbits_d = nbits_q + NBITS_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      nbits_q  <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      nbits_q  <= nbits_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign full    = full_q;
  assign empty   = empty_q;
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
